// File: rtl/bcd_to_bin_pkg.sv
// ============================================================================
// bcd_to_bin_pkg : shared FSM state type and fixed widths for bcd_to_bin
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_to_bin_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 10;
  localparam int N_ITER     = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_to_bin_if.sv
// ============================================================================
// bcd_to_bin_if : request/result bundle between decimal logic and bcd_to_bin
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bcd_to_bin_if;

  logic       start;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       ready;
  logic       done_tick;
  logic [9:0] bin;

  modport master (
    output start, bcd2, bcd1, bcd0,
    input  ready, done_tick, bin
  );

  modport slave (
    input  start, bcd2, bcd1, bcd0,
    output ready, done_tick, bin
  );

endinterface

`default_nettype wire

// File: rtl/bcd_to_bin_digit_adj.sv
// ============================================================================
// bcd_digit_adj : one-digit correction step, d >= 8 becomes d - 3
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adj (
  input  wire logic [3:0] i_d,
  output logic      [3:0] o_d
);

  assign o_d = (i_d >= 4'd8) ? (i_d - 4'd3) : i_d;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin.sv
// ============================================================================
// bcd_to_bin : sequential 3-digit BCD to 10-bit binary (reverse double dabble)
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_to_bin
  import bcd_to_bin_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   reset,
  bcd_to_bin_if.slave bus
);

  localparam int SH_W = 4 * BCD_DIGITS + BIN_W;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [4*BCD_DIGITS-1:0] r_bcd;
  logic [BIN_W-1:0]        r_bin;
  logic [3:0]              r_n;

  logic                    w_ready;
  logic                    w_done;
  logic                    w_load;
  logic                    w_step;
  logic [SH_W-1:0]         w_shift;
  logic [4*BCD_DIGITS-1:0] w_bcd_adj;

  // The BCD register's LSB shifts into the binary MSB each iteration.
  assign w_shift = {r_bcd, r_bin} >> 1;

  generate
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_d (w_shift[BIN_W + 4*g +: 4]),
        .o_d (w_bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = OP;
        end
      end
      OP: begin
        w_step = 1'b1;
        if (r_n == 4'd0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_n   <= '0;
    end else if (w_load) begin
      r_bcd <= {bus.bcd2, bus.bcd1, bus.bcd0};
      r_bin <= '0;
      r_n   <= 4'(N_ITER - 1);
    end else if (w_step) begin
      r_bcd <= w_bcd_adj;
      r_bin <= w_shift[BIN_W-1:0];
      r_n   <= r_n - 4'd1;
    end
  end

  assign bus.ready     = w_ready;
  assign bus.done_tick = w_done;
  assign bus.bin       = r_bin;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
// ============================================================================
// tb_bcd_to_bin : directed self-checking bench for bcd_to_bin
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bcd_to_bin;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  bcd_to_bin_if bus ();

  bcd_to_bin dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then return the edge count until done_tick (-1 on timeout).
  task automatic run_conv(input logic [3:0] d2, input logic [3:0] d1,
                          input logic [3:0] d0, output int lat);
    bus.bcd2  = d2;
    bus.bcd1  = d1;
    bus.bcd0  = d0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.done_tick === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.bcd2  = 4'd0;
    bus.bcd1  = 4'd0;
    bus.bcd0  = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", bus.ready);
    end
    vectors++;
    if (bus.done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", bus.done_tick);
    end
    vectors++;
    if (bus.bin !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_bin: got %0d expected 0", bus.bin);
    end
  endtask

  task automatic test_basic;
    int lat;
    run_conv(4'd1, 4'd3, 4'd1, lat);
    vectors++;
    if (lat != 10) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 10", lat);
    end
    vectors++;
    if (bus.bin !== 10'd131) begin
      miscompares++;
      $display("FAIL basic_bin: got %0d expected 131", bus.bin);
    end
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ready_in_done: got %b expected 0", bus.ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after: ready=%b done=%b expected ready=1 done=0",
               bus.ready, bus.done_tick);
    end
    vectors++;
    if (bus.bin !== 10'd131) begin
      miscompares++;
      $display("FAIL basic_hold: got %0d expected 131", bus.bin);
    end
  endtask

  task automatic test_extremes;
    int lat;
    run_conv(4'd9, 4'd9, 4'd9, lat);
    vectors++;
    if (lat != 10 || bus.bin !== 10'd999) begin
      miscompares++;
      $display("FAIL max_999: lat=%0d bin=%0d expected lat=10 bin=999", lat, bus.bin);
    end
    @(posedge clk); #1;
    run_conv(4'd0, 4'd0, 4'd0, lat);
    vectors++;
    if (lat != 10 || bus.bin !== 10'd0) begin
      miscompares++;
      $display("FAIL zero: lat=%0d bin=%0d expected lat=10 bin=0", lat, bus.bin);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_single_pulse: done=%b expected 0", bus.done_tick);
    end
    run_conv(4'd5, 4'd0, 4'd8, lat);
    vectors++;
    if (lat != 10 || bus.bin !== 10'd508) begin
      miscompares++;
      $display("FAIL mixed_508: lat=%0d bin=%0d expected lat=10 bin=508", lat, bus.bin);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_held;
    int pulses = 0;
    bus.bcd2  = 4'd2;
    bus.bcd1  = 4'd5;
    bus.bcd0  = 4'd6;
    bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i == 3) bus.start = 1'b0;
      if (bus.done_tick === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL held4_pulses: got %0d expected 1", pulses);
    end
    vectors++;
    if (bus.bin !== 10'd256 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL held4_bin: bin=%0d ready=%b expected bin=256 ready=1",
               bus.bin, bus.ready);
    end
  endtask

  task automatic test_back_to_back;
    int first = -1;
    int prev  = -1;
    int pulses = 0;
    bit idle_seen = 1'b0;
    bus.bcd2  = 4'd0;
    bus.bcd1  = 4'd4;
    bus.bcd0  = 4'd2;
    bus.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done_tick === 1'b1) begin
        pulses++;
        vectors++;
        if (bus.bin !== 10'd42) begin
          miscompares++;
          $display("FAIL b2b_bin: got %0d expected 42 at cycle %0d", bus.bin, i);
        end
        if (first < 0) begin
          first = i;
        end else begin
          vectors++;
          if (i - prev != 12) begin
            miscompares++;
            $display("FAIL b2b_period: got %0d expected 12", i - prev);
          end
        end
        prev = i;
      end
    end
    vectors++;
    if (first != 10 || pulses != 3) begin
      miscompares++;
      $display("FAIL b2b_count: first=%0d pulses=%0d expected first=10 pulses=3",
               first, pulses);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) begin
        idle_seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!idle_seen) begin
      miscompares++;
      $display("FAIL b2b_drain: ready=%b expected 1 within 20 cycles", bus.ready);
    end
  endtask

  task automatic test_input_change;
    int lat = -1;
    bus.bcd2  = 4'd1;
    bus.bcd1  = 4'd2;
    bus.bcd0  = 4'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bcd2  = 4'd5;
    bus.bcd1  = 4'd5;
    bus.bcd0  = 4'd5;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.done_tick === 1'b1) begin
        lat = k;
        break;
      end
    end
    vectors++;
    if (lat != 10 || bus.bin !== 10'd123) begin
      miscompares++;
      $display("FAIL input_change: lat=%0d bin=%0d expected lat=10 bin=123", lat, bus.bin);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    int lat;
    int pulses = 0;
    bus.bcd2  = 4'd9;
    bus.bcd1  = 4'd8;
    bus.bcd0  = 4'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (bus.bin !== 10'd0 || bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset: bin=%0d ready=%b done=%b expected bin=0 ready=1 done=0",
               bus.bin, bus.ready, bus.done_tick);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.done_tick === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL midop_no_done: got %0d pulses expected 0", pulses);
    end
    run_conv(4'd0, 4'd0, 4'd7, lat);
    vectors++;
    if (lat != 10 || bus.bin !== 10'd7) begin
      miscompares++;
      $display("FAIL midop_restart: lat=%0d bin=%0d expected lat=10 bin=7", lat, bus.bin);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.bcd2    = 4'd0;
    bus.bcd1    = 4'd0;
    bus.bcd0    = 4'd0;
    #2;
    test_reset();
    test_basic();
    test_extremes();
    test_start_held();
    test_back_to_back();
    test_input_change();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
